// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues PC addresses to instruction memory, tracks in-order
// responses in a DEPTH-entry ring and offers {pc, instr} pairs to decode.
module if_fetch_queue #(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_valid,
   input  logic [31:0] pc_addr,
   output logic        pc_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        flush,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr,
   input  logic        dec_ready
);

   typedef enum logic {RUN, DRAIN} state_t;

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);

   state_t             state_q, state_d;
   logic [PTR_W:0]     alloc_q, alloc_d;
   logic [PTR_W:0]     fill_q, fill_d;
   logic [PTR_W:0]     rd_q, rd_d;
   logic [PTR_W:0]     drop_q, drop_d;
   logic [31:0]        pc_mem_q [DEPTH];
   logic [31:0]        pc_mem_d [DEPTH];
   logic [31:0]        instr_mem_q [DEPTH];
   logic [31:0]        instr_mem_d [DEPTH];

   logic [PTR_W:0]     used;
   logic [PTR_W:0]     pending;
   logic               fill_en;
   logic               pop;

   assign used      = alloc_q - rd_q;
   assign pending   = alloc_q - fill_q;
   // rst gating keeps the PC from advancing while the block is held in reset
   assign imem_req  = pc_valid & (used < DEPTH_C) & ~flush & (state_q == RUN) & ~rst;
   assign pc_ready  = imem_req & imem_gnt;
   assign imem_addr = pc_addr;
   assign dec_valid = (fill_q != rd_q) & ~flush;
   assign dec_pc    = pc_mem_q[rd_q[PTR_W-1:0]];
   assign dec_instr = instr_mem_q[rd_q[PTR_W-1:0]];
   assign fill_en   = imem_rvalid & (state_q == RUN) & (pending != '0);
   assign pop       = dec_valid & dec_ready;

   always_comb begin
      state_d     = state_q;
      alloc_d     = alloc_q;
      fill_d      = fill_q;
      rd_d        = rd_q;
      drop_d      = drop_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (flush) begin
         fill_d = alloc_q;
         rd_d   = alloc_q;
         if (state_q == RUN) begin
            // a response landing in the flush cycle is already accounted for
            drop_d  = pending - (fill_en ? ONE_C : '0);
            state_d = (drop_d != '0) ? DRAIN : RUN;
         end else if (imem_rvalid) begin
            drop_d  = drop_q - ONE_C;
            state_d = (drop_q == ONE_C) ? RUN : DRAIN;
         end
      end else begin
         if (pc_ready) begin
            pc_mem_d[alloc_q[PTR_W-1:0]] = pc_addr;
            alloc_d = alloc_q + ONE_C;
         end
         if (fill_en) begin
            instr_mem_d[fill_q[PTR_W-1:0]] = imem_rdata;
            fill_d = fill_q + ONE_C;
         end
         if (pop) begin
            rd_d = rd_q + ONE_C;
         end
         if ((state_q == DRAIN) && imem_rvalid) begin
            drop_d  = drop_q - ONE_C;
            state_d = (drop_q == ONE_C) ? RUN : DRAIN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         alloc_q <= '0;
         fill_q  <= '0;
         rd_q    <= '0;
         drop_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         alloc_q     <= alloc_d;
         fill_q      <= fill_d;
         rd_q        <= rd_d;
         drop_q      <= drop_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

   // A response with nothing outstanding means the memory broke ordering
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(imem_rvalid && (state_q == RUN) && (pending == '0)))
         else $error("imem_rvalid with no outstanding request");
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order memory model plus a {pc, instr} scoreboard
// filled on every grant and drained on every decode pop.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_valid;
   logic [31:0] pc_addr;
   logic        pc_ready;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        flush;
   logic        dec_valid;
   logic [31:0] dec_pc;
   logic [31:0] dec_instr;
   logic        dec_ready;

   if_fetch_queue #(.DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pc_valid   (pc_valid),
      .pc_addr    (pc_addr),
      .pc_ready   (pc_ready),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .flush      (flush),
      .dec_valid  (dec_valid),
      .dec_pc     (dec_pc),
      .dec_instr  (dec_instr),
      .dec_ready  (dec_ready)
   );

   always #5 clk = ~clk;

   int          errs   = 0;
   int          checks = 0;
   int          pops   = 0;
   int          grants = 0;
   int          cyc    = 0;
   logic        mem_en;
   logic        last_acc;
   logic [31:0] inflight [$];
   logic [31:0] sb_pc [$];
   logic [31:0] sb_ins [$];

   function automatic logic [31:0] ins_of(input logic [31:0] a);
      return a ^ 32'h0050_0093;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Observe the cycle at the falling edge: record grants, score pops, honour flush.
   task automatic half();
      logic [31:0] epc, eins;
      @(negedge clk);
      cyc++;
      last_acc = pc_ready;
      if (pc_ready) begin
         grants++;
         inflight.push_back(imem_addr);
         sb_pc.push_back(imem_addr);
         sb_ins.push_back(ins_of(imem_addr));
      end
      if (dec_valid && dec_ready) begin
         pops++;
         if (sb_pc.size() == 0) begin
            chk("unexpected_pop", 32'd1, 32'd0);
         end else begin
            epc  = sb_pc.pop_front();
            eins = sb_ins.pop_front();
            chk("dec_pc", dec_pc, epc);
            chk("dec_instr", dec_instr, eins);
         end
      end
      if (flush) begin
         sb_pc.delete();
         sb_ins.delete();
      end
   endtask

   // Commit the edge, then let the memory answer the oldest outstanding request.
   task automatic fin();
      @(posedge clk);
      #1;
      if (mem_en && inflight.size() > 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ins_of(inflight.pop_front());
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
      end
   endtask

   task automatic drain(input string tag, input int exp_pops);
      int p0;
      p0        = pops;
      pc_valid  = 1'b0;
      dec_ready = 1'b1;
      mem_en    = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (sb_pc.size() == 0 && inflight.size() == 0 && !imem_rvalid) break;
         half();
         fin();
      end
      chk(tag, 32'(pops - p0), 32'(exp_pops));
   endtask

   task automatic single_fetch(input string tag);
      pc_valid  = 1'b1;
      pc_addr   = 32'h0;
      imem_gnt  = 1'b1;
      mem_en    = 1'b1;
      dec_ready = 1'b1;
      half();
      chk({tag, "_grant"}, 32'(pc_ready), 32'd1);
      chk({tag, "_addr"}, imem_addr, 32'h0);
      fin();
      pc_valid = 1'b0;
      half();
      chk({tag, "_n1_valid"}, 32'(dec_valid), 32'd0);
      fin();
      half();
      chk({tag, "_n2_valid"}, 32'(dec_valid), 32'd1);
      chk({tag, "_n2_instr"}, dec_instr, 32'h0050_0093);
      fin();
      drain({tag, "_pops"}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_pop, last_pop, p0, g0;
      rst         = 1'b1;
      pc_valid    = 1'b1;
      pc_addr     = 32'h40;
      imem_gnt    = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      flush       = 1'b0;
      dec_ready   = 1'b0;
      mem_en      = 1'b0;
      last_acc    = 1'b0;

      // reset state, with a fetch request already pending
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_pc_ready", 32'(pc_ready), 32'd0);
      chk("rst_dec_pc", dec_pc, 32'd0);
      chk("rst_dec_instr", dec_instr, 32'd0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      pc_valid = 1'b0;

      single_fetch("single");

      // streaming 0x0..0x1C, one grant and one response per cycle
      pc_valid  = 1'b1;
      pc_addr   = 32'h0;
      dec_ready = 1'b1;
      mem_en    = 1'b1;
      p0        = pops;
      first_pop = -1;
      last_pop  = -1;
      for (int i = 0; i < 30; i++) begin
         half();
         if (pops != p0) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            p0       = pops;
         end
         if (pc_valid) chk("stream_pc_ready", 32'(pc_ready), 32'd1);
         fin();
         if (last_acc) begin
            pc_addr += 32'd4;
            if (pc_addr > 32'h1C) pc_valid = 1'b0;
         end
         if (!pc_valid && sb_pc.size() == 0 && inflight.size() == 0 && !imem_rvalid) break;
      end
      chk("stream_span", 32'(last_pop - first_pop), 32'd7);
      chk("stream_left", 32'(sb_pc.size()), 32'd0);

      // backpressure: decode stalled, queue fills at four
      pc_valid  = 1'b1;
      pc_addr   = 32'h200;
      dec_ready = 1'b0;
      g0        = grants;
      for (int i = 0; i < 6; i++) begin
         half();
         fin();
         if (last_acc) pc_addr += 32'd4;
      end
      chk("full_grants", 32'(grants - g0), 32'd4);
      half();
      chk("full_blocked", 32'(pc_ready), 32'd0);
      fin();
      dec_ready = 1'b1;
      half();
      chk("full_pop_same_cycle", 32'(pc_ready), 32'd0);
      fin();
      dec_ready = 1'b0;
      half();
      chk("full_after_pop", 32'(pc_ready), 32'd1);
      chk("full_after_pop_addr", imem_addr, 32'h210);
      fin();
      if (last_acc) pc_addr += 32'd4;
      half();
      chk("full_again", 32'(pc_ready), 32'd0);
      fin();
      drain("full_drain", 4);

      // flush with two in flight, first response coincident with flush
      pc_valid  = 1'b1;
      pc_addr   = 32'h300;
      dec_ready = 1'b1;
      mem_en    = 1'b0;
      half();
      chk("fl2_grant_a", 32'(pc_ready), 32'd1);
      fin();
      pc_addr = 32'h304;
      half();
      chk("fl2_grant_b", 32'(pc_ready), 32'd1);
      mem_en = 1'b1;
      fin();
      flush   = 1'b1;
      pc_addr = 32'h100;
      half();
      chk("fl2_rvalid", 32'(imem_rvalid), 32'd1);
      chk("fl2_req_flush", 32'(imem_req), 32'd0);
      chk("fl2_dv_flush", 32'(dec_valid), 32'd0);
      fin();
      flush = 1'b0;
      half();
      chk("fl2_req_drain", 32'(imem_req), 32'd0);
      chk("fl2_dv_drain", 32'(dec_valid), 32'd0);
      fin();
      half();
      chk("fl2_resume", 32'(pc_ready), 32'd1);
      chk("fl2_resume_addr", imem_addr, 32'h100);
      fin();
      drain("fl2_drain", 1);

      // flush with three filled entries and nothing in flight
      pc_valid  = 1'b1;
      pc_addr   = 32'h400;
      dec_ready = 1'b0;
      g0        = grants;
      for (int i = 0; i < 3; i++) begin
         half();
         fin();
         if (last_acc) pc_addr += 32'd4;
      end
      chk("fl3_grants", 32'(grants - g0), 32'd3);
      pc_valid = 1'b0;
      repeat (2) begin
         half();
         fin();
      end
      half();
      chk("fl3_dv_before", 32'(dec_valid), 32'd1);
      fin();
      flush    = 1'b1;
      pc_valid = 1'b1;
      pc_addr  = 32'h500;
      half();
      chk("fl3_req_flush", 32'(imem_req), 32'd0);
      fin();
      flush = 1'b0;
      half();
      chk("fl3_dv_after", 32'(dec_valid), 32'd0);
      chk("fl3_issue", 32'(pc_ready), 32'd1);
      fin();
      drain("fl3_drain", 1);

      // asynchronous reset between clock edges in the middle of a stream
      pc_valid  = 1'b1;
      pc_addr   = 32'h600;
      dec_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         half();
         fin();
         if (last_acc) pc_addr += 32'd4;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dec_valid", 32'(dec_valid), 32'd0);
      chk("arst_imem_req", 32'(imem_req), 32'd0);
      chk("arst_pc_ready", 32'(pc_ready), 32'd0);
      inflight.delete();
      sb_pc.delete();
      sb_ins.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pc_valid    = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      single_fetch("post_rst");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
